// File: rtl/inv_aes_pkg.sv
// Shared types and parameter defaults for the inverse-cipher controller.
package inv_aes_pkg;

    typedef logic [0:127] block_t;

    typedef enum logic [2:0] {
        WAIT_KEY,
        SETTLE,
        RUN,
        DRAIN,
        LOAD
    } state_t;

    localparam int PIPE_LAT_DEF   = 41;
    localparam int FIFO_DEPTH_DEF = 64;

endpackage

// File: rtl/inv_cipher_ctrl_fifo.sv
// Synchronous output FIFO; a write while full is accepted only alongside a pop.
module inv_cipher_ctrl_fifo
    import inv_aes_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [0:127]  wr_data,
    input  logic          rd_en,
    output logic [0:127]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    block_t      mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_wr;
    logic        do_rd;

    assign count   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + (AW + 1)'(1);
            if (do_rd) rptr <= rptr + (AW + 1)'(1);
        end
    end

endmodule

// File: rtl/inv_cipher_ctrl.sv
// Inverse-cipher pipeline controller: key sequencing, credit-gated admission, output buffering.
// Define INV_CIPHER_CTRL_STATS_EN to add the blk_count output (count of output pops).
//
//   state    | meaning
//   WAIT_KEY | idle after reset, waiting for the first block to supply a key
//   LOAD     | latch the key into cur_key/dp_key, arm the settle timer
//   SETTLE   | let the pipeline absorb the new key; no admission
//   RUN      | admit blocks carrying cur_key while credit remains
//   DRAIN    | key change requested; wait for the pipeline to empty
module inv_cipher_ctrl
    import inv_aes_pkg::*;
#(
    parameter int PIPE_LAT   = PIPE_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [0:127]  in_ct,
    input  logic [0:127]  in_key,
    output logic [0:127]  dp_ciphertext,
    output logic [0:127]  dp_key,
    input  logic [0:127]  dp_plaintext,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:127]  out_pt,
    output logic          busy
`ifdef INV_CIPHER_CTRL_STATS_EN
    ,
    output logic [31:0]   blk_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(PIPE_LAT + 1);

    state_t                state;
    block_t                cur_key;
    logic [SW-1:0]         settle_cnt;
    logic [PIPE_LAT-1:0]   vld_sr;
    logic [CW-1:0]         in_flight;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           outstanding;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  key_match;
    logic                  credit_ok;
    logic                  accept;
    logic                  tap;
    logic                  pop;

    assign key_match   = (in_key == cur_key);
    assign outstanding = {1'b0, in_flight} + {1'b0, fifo_count};
    assign credit_ok   = (outstanding < (CW + 1)'(FIFO_DEPTH));
    // Combinational so that a key mismatch blocks the very block that carries it.
    assign in_ready    = (state == RUN) && key_match && credit_ok;
    assign accept      = in_valid && in_ready;
    assign tap         = vld_sr[PIPE_LAT-1];
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign busy        = (in_flight != '0) || !fifo_empty ||
                         (state == SETTLE) || (state == DRAIN) || (state == LOAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_KEY;
            cur_key    <= '0;
            dp_key     <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                WAIT_KEY: if (in_valid) state <= LOAD;
                LOAD: begin
                    cur_key    <= in_key;
                    dp_key     <= in_key;
                    settle_cnt <= SW'(PIPE_LAT);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt <= SW'(1)) begin
                        settle_cnt <= '0;
                        state      <= RUN;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                RUN:     if (in_valid && !key_match) state <= DRAIN;
                DRAIN:   if (in_flight == '0) state <= LOAD;
                default: state <= WAIT_KEY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_ciphertext <= '0;
            vld_sr        <= '0;
            in_flight     <= '0;
        end else begin
            if (accept) dp_ciphertext <= in_ct;
            vld_sr[0] <= accept;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
            case ({accept, tap})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    inv_cipher_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (tap),
        .wr_data (dp_plaintext),
        .rd_en   (pop),
        .rd_data (out_pt),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Admission credit makes this unreachable; firing means the credit math is broken.
    assert property (@(posedge clk) disable iff (!reset_n) !(tap && fifo_full && !pop));

`ifdef INV_CIPHER_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_count <= '0;
        end else if (pop) begin
            blk_count <= blk_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Self-checking bench for inv_cipher_ctrl with a behavioural datapath peer and an expected-output queue.
module tb_inv_cipher_ctrl;

    localparam int PIPE_LAT   = 41;
    localparam int FIFO_DEPTH = 64;
    localparam logic [0:127] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] KAT_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:127] in_ct = '0;
    logic [0:127] in_key = '0;
    logic [0:127] dp_ciphertext;
    logic [0:127] dp_key;
    logic [0:127] dp_plaintext;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [0:127] out_pt;
    logic         busy;
`ifdef INV_CIPHER_CTRL_STATS_EN
    logic [31:0]  blk_count;
`endif

    logic [0:127] dp_pipe [PIPE_LAT-1];
    logic [0:127] exp_q [$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           n_pops = 0;
    logic         rand_ready_en = 1'b0;

    always #5 clk = ~clk;

    inv_cipher_ctrl #(
        .PIPE_LAT   (PIPE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ct         (in_ct),
        .in_key        (in_key),
        .dp_ciphertext (dp_ciphertext),
        .dp_key        (dp_key),
        .dp_plaintext  (dp_plaintext),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pt        (out_pt),
        .busy          (busy)
`ifdef INV_CIPHER_CTRL_STATS_EN
        ,
        .blk_count     (blk_count)
`endif
    );

    // Stand-in cipher: exact for the known-answer vector, a keyed bijection otherwise.
    function automatic logic [0:127] ref_decrypt(input logic [0:127] ct, input logic [0:127] key);
        logic [0:127] k;
        if (ct == KAT_CT && key == KAT_KEY) return KAT_PT;
        k = key;
        return ct ^ {k[64:127], k[0:63]} ^ 128'h5a5a_3c3c_a5a5_c3c3_0f0f_f0f0_9696_6969;
    endfunction

    function automatic logic [0:127] rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Datapath peer: plaintext for the ciphertext/key present at edge N is visible after edge N+PIPE_LAT-1.
    always @(posedge clk) begin
        dp_pipe[0] <= ref_decrypt(dp_ciphertext, dp_key);
        for (int i = 1; i < PIPE_LAT - 1; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign dp_plaintext = dp_pipe[PIPE_LAT-2];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accept predicts one output, in order; no output without a prediction.
    always @(negedge clk) begin
        if (reset_n) begin
            if (exp_q.size() == 0) begin
                check_val("no_stale_out_valid", 128'(out_valid), 128'(0));
            end else if (out_valid && out_ready) begin
                check_val("out_pt_order", out_pt, exp_q.pop_front());
                n_pops++;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_decrypt(in_ct, in_key));
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Called just after a rising edge; returns just after the accepting edge with in_valid low.
    task automatic send_block(input logic [0:127] ct, input logic [0:127] key, output int stalls);
        in_valid = 1'b1;
        in_ct    = ct;
        in_key   = key;
        stalls   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
            if (stalls > 400) begin
                check_val("send_timeout", 128'(in_ready), 128'(1));
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_complete", 128'(exp_q.size()), 128'(0));
        check_val("idle_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
    endtask

    // Presents the known-answer block and measures in_ready rise and output latency.
    task automatic kat_run(input int exp_ready_lat, input string tag);
        int n;
        in_valid = 1'b1;
        in_key   = KAT_KEY;
        in_ct    = KAT_CT;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready || n > 400) break;
            @(posedge clk);
            n++;
        end
        check_val({tag, "_in_ready_latency"}, 128'(n), 128'(exp_ready_lat));
        check_val({tag, "_dp_key"}, dp_key, KAT_KEY);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val({tag, "_dp_ciphertext"}, dp_ciphertext, KAT_CT);
        n = 1;
        forever begin
            @(negedge clk);
            if (out_valid || n > 400) break;
            @(posedge clk);
            n++;
        end
        check_val({tag, "_out_valid_latency"}, 128'(n), 128'(PIPE_LAT + 1));
        check_val({tag, "_pt"}, out_pt, KAT_PT);
        @(posedge clk); #1;
    endtask

    initial begin
        int           n;
        int           stalls;
        int           total_stalls;
        int           pops0;
        logic [0:127] k1;
        logic         key_sel;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", 128'(in_ready), 128'(0));
        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_dp_key", dp_key, 128'(0));
        check_val("rst_dp_ct", dp_ciphertext, 128'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;

        // First key: WAIT_KEY -> LOAD -> SETTLE(PIPE_LAT) -> RUN
        out_ready = 1'b1;
        kat_run(PIPE_LAT + 2, "kat0");
        wait_idle();

        // 100 back-to-back blocks under one key
        pops0 = n_pops;
        total_stalls = 0;
        for (int i = 0; i < 100; i++) begin
            send_block(rand_block(), KAT_KEY, stalls);
            total_stalls += stalls;
        end
        check_val("b2b_stalls", 128'(total_stalls), 128'(0));
        wait_idle();
        check_val("b2b_count", 128'(n_pops - pops0), 128'(100));

        // Output stalled: admission stops at FIFO_DEPTH outstanding
        out_ready = 1'b0;
        pops0 = n_pops;
        n = 0;
        in_valid = 1'b1;
        in_key = KAT_KEY;
        forever begin
            in_ct = rand_block();
            @(negedge clk);
            if (!in_ready || n > 200) break;
            @(posedge clk); #1;
            n++;
        end
        check_val("credit_accepts", 128'(n), 128'(FIFO_DEPTH));
        check_val("credit_outstanding", 128'(exp_q.size()), 128'(FIFO_DEPTH));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (PIPE_LAT + 10) @(posedge clk);
        @(negedge clk);
        check_val("credit_full_out_valid", 128'(out_valid), 128'(1));
        check_val("credit_full_in_ready", 128'(in_ready), 128'(0));
        check_val("credit_full_busy", 128'(busy), 128'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle();
        check_val("credit_drain_count", 128'(n_pops - pops0), 128'(FIFO_DEPTH));

        // Key change after 5 blocks: retire (PIPE_LAT) + DRAIN exit + LOAD + SETTLE (PIPE_LAT)
        k1 = rand_block();
        for (int i = 0; i < 5; i++) send_block(rand_block(), k1, stalls);
        kat_run(2 * PIPE_LAT + 2, "keychg");
        wait_idle();

        // Randomized traffic, key flips, gaps and back-pressure
        pops0 = n_pops;
        key_sel = 1'b0;
        rand_ready_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) key_sel = !key_sel;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send_block(rand_block(), key_sel ? k1 : KAT_KEY, stalls);
        end
        rand_ready_en = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_idle();
        check_val("rand_count", 128'(n_pops - pops0), 128'(60));

        // Reset with 10 blocks in flight
        for (int i = 0; i < 10; i++) send_block(rand_block(), KAT_KEY, stalls);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_val("midrst_out_valid", 128'(out_valid), 128'(0));
        check_val("midrst_busy", 128'(busy), 128'(0));
        check_val("midrst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2 * PIPE_LAT + 10) @(posedge clk);
        @(negedge clk);
        check_val("postrst_out_valid", 128'(out_valid), 128'(0));
        check_val("postrst_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        kat_run(PIPE_LAT + 2, "kat_postrst");
        wait_idle();

`ifdef INV_CIPHER_CTRL_STATS_EN
        reset_n = 1'b0;
        #2;
        check_val("stats_rst", 128'(blk_count), 128'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) send_block(rand_block(), KAT_KEY, stalls);
        wait_idle();
        check_val("stats_seven", 128'(blk_count), 128'(7));
        @(negedge clk);
        force dut.blk_count = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.blk_count;
        send_block(rand_block(), KAT_KEY, stalls);
        wait_idle();
        check_val("stats_wrap", 128'(blk_count), 128'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inv_cipher_ctrl.md
INV_CIPHER_CTRL -- requirements
Module: inv_cipher_ctrl

Interface
REQ-001 Parameter PIPE_LAT, default 41: cycles from the datapath input capture to a valid dp_plaintext.
REQ-002 Parameter FIFO_DEPTH, default 64 (power of two, at least 2): output buffer entries.
REQ-003 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  requester offers a block.
REQ-007 in_ready  out  1  controller accepts the block; transfer occurs when in_valid && in_ready.
REQ-008 in_ct  in  128  ciphertext, bit 0 = MSB.
REQ-009 in_key  in  128  cipher key for this block.
REQ-010 dp_ciphertext  out  128  registered ciphertext driven into the inverse-cipher pipeline.
REQ-011 dp_key  out  128  registered key driven into the pipeline; held stable between key loads.
REQ-012 dp_plaintext  in  128  registered plaintext returned by the pipeline.
REQ-013 out_valid  out  1  / out_ready  in  1  / out_pt  out  128: output valid/ready handshake.
REQ-014 busy  out  1  blocks in flight or buffered, or a key change in progress.

Function
REQ-015 FSM states: WAIT_KEY, SETTLE, RUN, DRAIN, LOAD; reset state is WAIT_KEY.
REQ-016 WAIT_KEY: in_ready=0; in_valid=1 moves to LOAD.
REQ-017 LOAD: single cycle; cur_key and dp_key take in_key; settle counter loads PIPE_LAT; next state is SETTLE.
REQ-018 SETTLE: in_ready=0; counter decrements each cycle; at 0 the FSM moves to RUN.
REQ-019 RUN: in_ready=1 only when in_key==cur_key and in_flight+fifo_count < FIFO_DEPTH.
REQ-020 RUN with in_valid=1 and in_key!=cur_key: in_ready=0, and the FSM moves to DRAIN.
REQ-021 DRAIN: in_ready=0 until in_flight==0, then the FSM moves to LOAD; buffered FIFO output continues draining.
REQ-022 Accept: dp_ciphertext takes in_ct on the accepting edge; otherwise it holds its value.
REQ-023 A PIPE_LAT-deep valid shift register tracks accepts.
REQ-024 The tap of an accept at edge N fires at edge N+PIPE_LAT; on that edge dp_plaintext is written into the FIFO.
REQ-025 in_flight counter: +1 per accept, -1 per tap; both in the same cycle leaves it unchanged.
REQ-026 The credit rule in REQ-019 guarantees no FIFO overflow; a write to a full FIFO is a design error, flagged by an assertion.
REQ-027 out_valid = FIFO not empty; out_pt = FIFO head; a pop occurs on out_valid && out_ready.
REQ-028 Minimum latency from accept to out_valid is PIPE_LAT+1 cycles; blocks emerge in accept order.
REQ-029 A simultaneous FIFO write and pop is legal at any occupancy, including empty with a bypass disallowed and full.
REQ-030 busy = (in_flight!=0) || FIFO non-empty || state is one of SETTLE, DRAIN, LOAD.

Reset
REQ-031 Reset clears: FSM to WAIT_KEY; dp_ciphertext, dp_key, cur_key, the shift register, in_flight, the FIFO pointers and the settle counter to 0.
REQ-032 After reset: in_ready=0, out_valid=0, busy=0.
REQ-033 Reset mid-operation discards all in-flight and buffered blocks; no stale out_valid follows deassertion.

Configuration
REQ-034 Macro INV_CIPHER_CTRL_STATS_EN defined adds port blk_count  out  32, a count of output pops.
REQ-035 blk_count resets to 0 and wraps from 0xFFFFFFFF to 0.
REQ-036 With the macro undefined, the port and counter are absent; all other behaviour is identical.

Structure
REQ-037 Package inv_aes_pkg holds: the block type (128-bit, bit 0 = MSB), the FSM state enum, and PIPE_LAT/FIFO_DEPTH defaults.
REQ-038 One sub-module, inv_cipher_ctrl_fifo: synchronous FIFO with full/empty/count outputs.
REQ-039 The datapath is instantiated outside this block, as its peer.

Verification
REQ-040 Pipeline bound, key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out_pt 00112233445566778899aabbccddeeff.
REQ-041 Timing for REQ-040: in_ready rises PIPE_LAT+2 cycles after the first in_valid, and out_valid appears PIPE_LAT+1 cycles after the accept.
REQ-042 100 back-to-back blocks with the same key and out_ready=1 -> one accept per cycle in RUN, outputs in order with none lost.
REQ-043 out_ready=0 held while streaming -> in_ready drops once in_flight+fifo_count=64; releasing it drains all 64 in order.
REQ-044 Key change after 5 blocks -> in_ready stays 0 until those 5 retire plus LOAD+SETTLE; the new-key vector then decrypts correctly.
REQ-045 reset_n pulsed low with 10 blocks in flight -> out_valid=0 and busy=0 immediately; no output appears before a new accept.
REQ-046 With INV_CIPHER_CTRL_STATS_EN, 7 pops -> blk_count=7; with the counter preset to 0xFFFFFFFF, one pop -> blk_count=0.
